// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous input, resettable to a given level.
module uart_rx_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= {STAGES{RESET_VAL}};
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, valid/ready byte output.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 with parity checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned DIVI = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF = DIVI / 2;
  localparam int unsigned CW   = (DIVI > 1) ? $clog2(DIVI) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIVI - 1);

  logic          rx_s;
  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_ok_c;

  uart_rx_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign byte_ok_c = !par_bad;
`else
  assign byte_ok_c  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Frame FSM, shift register and output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Consumer takes the byte; a completion below may reload it.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt        <= '0;
            par_bad    <= ^{shreg, rx_s};
            parity_err <= ^{shreg, rx_s};
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        ST_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              if (byte_ok_c) begin
                if (!valid || ready) begin
                  data  <= shreg;
                  valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIVI=10 with randomized payloads.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int          DIVI     = 10;
`ifdef UART_RX_PARITY_EN
  localparam int          LAT_NOM  = 9 * DIVI + DIVI / 2 + 3 + DIVI;
`else
  localparam int          LAT_NOM  = 9 * DIVI + DIVI / 2 + 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         n_perr = 0;
  int         rise_cyc = -1;
  logic       valid_d = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  // Observe outputs on the falling edge: acceptances, valid rise time, error pulse cycles.
  always @(negedge clk) begin
    if (valid && !valid_d && rise_cyc < 0) rise_cyc = cyc;
    valid_d = valid;
    if (valid && ready) got_q.push_back(data);
    if (frame_err)  n_ferr++;
    if (overrun)    n_ovr++;
    if (parity_err) n_perr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: byte value reassembled from the serial bit sequence, LSB first.
  function automatic logic [7:0] serial_value(input logic [7:0] b);
    int v;
    logic bits[8];
    for (int i = 0; i < 8; i++) bits[i] = b[i];
    v = 0;
    for (int i = 0; i < 8; i++) v = v + (bits[i] ? (1 << i) : 0);
    return 8'(v);
  endfunction

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                            input logic par_ok);
    drive_bit(1'b0, DIVI);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DIVI);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok, DIVI);
`endif
    drive_bit(stop_v, stop_len);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic compare_queues(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int ferr0, ovr0, perr0, lat, start_cyc;
    logic [7:0] b;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({data, valid, frame_err, overrun, parity_err}), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(20);

    // 1: single byte, latency window
    rise_cyc  = -1;
    start_cyc = cyc;
    send_frame(8'h42, 1'b1, DIVI, 1'b1);
    exp_q.push_back(serial_value(8'h42));
    idle(20);
    lat = rise_cyc - start_cyc;
    chk("t1_latency_window", 32'((lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1)), 32'd1);
    chk("t1_errors", 32'(n_ferr + n_ovr + n_perr), 32'd0);
    compare_queues("t1");

    // 2: overrun with ready held low
    ovr0  = n_ovr;
    ready = 1'b0;
    send_frame(8'hA5, 1'b1, DIVI, 1'b1);
    send_frame(8'h3C, 1'b1, DIVI, 1'b1);
    idle(10);
    chk("t2_valid_held", 32'(valid), 32'd1);
    chk("t2_data_kept", 32'(data), 32'hA5);
    chk("t2_overrun_pulses", 32'(n_ovr - ovr0), 32'd1);
    ready = 1'b1;
    exp_q.push_back(serial_value(8'hA5));
    idle(5);
    chk("t2_valid_cleared", 32'(valid), 32'd0);
    compare_queues("t2");

    // 3: bad stop bit, break, then recovery
    ferr0 = n_ferr;
    send_frame(8'h55, 1'b0, 30, 1'b1);
    chk("t3_valid_low_in_break", 32'(valid), 32'd0);
    idle(20);
    chk("t3_frame_err_pulses", 32'(n_ferr - ferr0), 32'd1);
    send_frame(8'h0F, 1'b1, DIVI, 1'b1);
    exp_q.push_back(serial_value(8'h0F));
    idle(20);
    chk("t3_frame_err_after", 32'(n_ferr - ferr0), 32'd1);
    compare_queues("t3");

    // 4: short glitch on idle line
    ferr0 = n_ferr; ovr0 = n_ovr; perr0 = n_perr;
    drive_bit(1'b0, 3);
    idle(40);
    chk("t4_errors", 32'((n_ferr - ferr0) + (n_ovr - ovr0) + (n_perr - perr0)), 32'd0);
    compare_queues("t4_none");
    send_frame(8'hC3, 1'b1, DIVI, 1'b1);
    exp_q.push_back(serial_value(8'hC3));
    idle(20);
    compare_queues("t4_after");

    // 5: reset in the middle of bit 4
    b = 8'h99;
    drive_bit(1'b0, DIVI);
    for (int i = 0; i < 4; i++) drive_bit(b[i], DIVI);
    rx = b[4];
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    rx      = 1'b1;
    @(negedge clk);
    chk("t5_outputs_in_reset", 32'({data, valid, frame_err, overrun, parity_err}), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(30);
    send_frame(8'h81, 1'b1, DIVI, 1'b1);
    exp_q.push_back(serial_value(8'h81));
    idle(20);
    compare_queues("t5");

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    perr0 = n_perr;
    send_frame(8'h07, 1'b1, DIVI, 1'b1);
    exp_q.push_back(serial_value(8'h07));
    idle(20);
    send_frame(8'h07, 1'b1, DIVI, 1'b0);
    idle(20);
    chk("t6_parity_err_pulses", 32'(n_perr - perr0), 32'd1);
    compare_queues("t6");
`endif

    // Random bytes with random idle gaps, including back-to-back frames
    ferr0 = n_ferr; ovr0 = n_ovr;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, DIVI, 1'b1);
      exp_q.push_back(serial_value(b));
      idle($urandom_range(0, 15));
    end
    idle(20);
    chk("rand_errors", 32'((n_ferr - ferr0) + (n_ovr - ovr0)), 32'd0);
    compare_queues("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
